// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Issue stage in front of the ALU. It takes decoded instructions over a
// valid/ready handshake, reads both operands from an internal register file
// and hands a registered opcode/operand/tag bundle to the ALU. The writeback
// port updates the register file and retires scoreboard entries. Operands are
// bypassed straight from a same-cycle writeback. Issue stalls while a source
// register or the destination register still has a result in flight.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready instruction handshake; in_ready never looks at in_valid
//   in_opcode         ALU opcode, passed through unchanged
//   in_rd             destination register
//   in_rs_a, in_rs_b  source registers (in_rs_b unused when in_use_imm=1)
//   in_imm            immediate, sign-extended to DATA_W
//   in_use_imm        1: data_b is the immediate instead of reg[in_rs_b]
//   out_valid/out_ready  ALU-side handshake
//   out_opcode, out_data_a, out_data_b, out_rd  registered ALU bundle
//   wb_en, wb_addr, wb_data  writeback into the register file
//   pending           scoreboard, one bit per register (bit 0 always 0)
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int DATA_W   = 32,
    parameter int OPC_W    = 5,
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 4,
    parameter int IMM_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPC_W-1:0]    in_opcode,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [REG_W-1:0]    in_rs_a,
    input  logic [REG_W-1:0]    in_rs_b,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic                in_use_imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPC_W-1:0]    out_opcode,
    output logic [DATA_W-1:0]   out_data_a,
    output logic [DATA_W-1:0]   out_data_b,
    output logic [REG_W-1:0]    out_rd,
    input  logic                wb_en,
    input  logic [REG_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] pending
);

    localparam logic [NUM_REGS-1:0] ONE_HOT_0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   opnd_a;
    logic [DATA_W-1:0]   opnd_b;
    logic [NUM_REGS-1:0] wb_clear;
    logic [NUM_REGS-1:0] rd_set;
    logic [NUM_REGS-1:0] busy;
    logic                hazard;
    logic                accept;

    assign imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    // A writeback retires its scoreboard entry in the same cycle, so a
    // register being written right now no longer blocks issue.
    assign wb_clear = wb_en ? (ONE_HOT_0 << wb_addr) : '0;
    assign busy     = pending & ~wb_clear;
    assign hazard   = busy[in_rs_a] || (!in_use_imm && busy[in_rs_b]) || busy[in_rd];

    assign in_ready = rst_n && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign rd_set   = (accept && in_rd != '0) ? (ONE_HOT_0 << in_rd) : '0;

    // NOTE: every variable driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        opnd_a = regs[in_rs_a];
        if (wb_en && wb_addr == in_rs_a) opnd_a = wb_data;
        if (in_rs_a == '0)               opnd_a = '0;

        opnd_b = regs[in_rs_b];
        if (wb_en && wb_addr == in_rs_b) opnd_b = wb_data;
        if (in_rs_b == '0)               opnd_b = '0;
        if (in_use_imm)                  opnd_b = imm_ext;
    end

    // NOTE: register files are normally left unreset, but this one must
    // come out of reset all-zero, so every entry is cleared here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            // Set is applied after clear so a same-cycle set of the same bit wins.
            pending <= (pending & ~wb_clear) | rd_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_data_a <= '0;
            out_data_b <= '0;
            out_rd     <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= in_opcode;
            out_data_a <= opnd_a;
            out_data_b <= opnd_b;
            out_rd     <= in_rd;
        end else if (out_ready) begin
            // Payload is left as-is; only the valid flag drops.
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//
// Directed scenarios followed by a randomized phase. A behavioural model
// (register array, pending flags, one output slot) predicts in_ready, the
// output bundle and the scoreboard every cycle.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int DATA_W   = 32;
    localparam int OPC_W    = 5;
    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int IMM_W    = 16;

    // Stand-in opcode values; the stage passes them through untouched.
    localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd4;
    localparam logic [OPC_W-1:0] OP_XOR = 5'd5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [OPC_W-1:0]    in_opcode;
    logic [REG_W-1:0]    in_rd;
    logic [REG_W-1:0]    in_rs_a;
    logic [REG_W-1:0]    in_rs_b;
    logic [IMM_W-1:0]    in_imm;
    logic                in_use_imm;
    logic                out_valid;
    logic                out_ready;
    logic [OPC_W-1:0]    out_opcode;
    logic [DATA_W-1:0]   out_data_a;
    logic [DATA_W-1:0]   out_data_b;
    logic [REG_W-1:0]    out_rd;
    logic                wb_en;
    logic [REG_W-1:0]    wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic [NUM_REGS-1:0] pending;

    operand_fetch #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .NUM_REGS(NUM_REGS), .REG_W(REG_W), .IMM_W(IMM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_data_a(out_data_a), .out_data_b(out_data_b), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    bit                m_pend [NUM_REGS];
    bit                m_ov;
    logic [OPC_W-1:0]  m_opc;
    logic [DATA_W-1:0] m_a;
    logic [DATA_W-1:0] m_b;
    logic [REG_W-1:0]  m_rd;

    // Observations from the most recent cycle()
    bit last_ready;
    bit last_hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        m_ov  = 1'b0;
        m_opc = '0;
        m_a   = '0;
        m_b   = '0;
        m_rd  = '0;
    endtask

    // Value a source register presents this cycle, writeback included.
    function automatic logic [DATA_W-1:0] m_value(input int r);
        if (r == 0) return '0;
        if (wb_en && int'(wb_addr) == r) return wb_data;
        return m_regs[r];
    endfunction

    // Register still waiting on a result that is not arriving this cycle.
    function automatic bit m_waiting(input int r);
        return (r != 0) && m_pend[r] && !(wb_en && int'(wb_addr) == r);
    endfunction

    // One clock: sample and compare just after inputs settle, advance the
    // model, then return at the following falling edge.
    task automatic cycle();
        bit                  exp_ready;
        bit                  acc;
        logic [NUM_REGS-1:0] exp_pend;
        logic [DATA_W-1:0]   na;
        logic [DATA_W-1:0]   nb;
        #1;
        exp_ready = rst_n && (!m_ov || out_ready) &&
                    !(m_waiting(int'(in_rs_a)) ||
                      (!in_use_imm && m_waiting(int'(in_rs_b))) ||
                      m_waiting(int'(in_rd)));
        for (int r = 0; r < NUM_REGS; r++) exp_pend[r] = m_pend[r];
        last_ready = in_ready;
        last_hs    = out_valid && out_ready;
        check("in_ready",   32'(in_ready),   32'(exp_ready));
        check("out_valid",  32'(out_valid),  32'(m_ov));
        check("out_opcode", 32'(out_opcode), 32'(m_opc));
        check("out_data_a", out_data_a,      m_a);
        check("out_data_b", out_data_b,      m_b);
        check("out_rd",     32'(out_rd),     32'(m_rd));
        check("pending",    32'(pending),    32'(exp_pend));

        if (!rst_n) begin
            model_reset();
        end else begin
            acc = in_valid && exp_ready;
            na  = m_value(int'(in_rs_a));
            nb  = in_use_imm ? DATA_W'($signed(in_imm)) : m_value(int'(in_rs_b));
            if (acc) begin
                m_ov  = 1'b1;
                m_opc = in_opcode;
                m_a   = na;
                m_b   = nb;
                m_rd  = in_rd;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (wb_en && wb_addr != '0) m_regs[wb_addr] = wb_data;
            if (wb_en) m_pend[wb_addr] = 1'b0;
            if (acc && in_rd != '0) m_pend[in_rd] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        wb_en     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic issue(input logic [OPC_W-1:0] opc, input int rd, input int rs_a,
                         input int rs_b, input logic [IMM_W-1:0] imm, input bit use_imm);
        in_valid   = 1'b1;
        in_opcode  = opc;
        in_rd      = REG_W'(rd);
        in_rs_a    = REG_W'(rs_a);
        in_rs_b    = REG_W'(rs_b);
        in_imm     = imm;
        in_use_imm = use_imm;
    endtask

    task automatic wb(input int addr, input logic [DATA_W-1:0] data);
        wb_en   = 1'b1;
        wb_addr = REG_W'(addr);
        wb_data = data;
    endtask

    initial begin
        int acc_cnt;
        int hs_cnt;

        rst_n      = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs_a    = '0;
        in_rs_b    = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        idle();
        model_reset();

        // Reset: outputs zero, in_ready held low even with a request present
        @(negedge clk);
        issue(OP_ADD, 1, 0, 0, 16'h0, 1'b1);
        cycle();
        check("rst_in_ready", 32'(last_ready), 32'd0);
        rst_n = 1'b1;
        idle();
        cycle();

        // 1: wb r3=5, then ADD rd=1 rs_a=3 imm=0xFFFF
        wb(3, 32'd5);
        cycle();
        idle();
        issue(OP_ADD, 1, 3, 0, 16'hFFFF, 1'b1);
        cycle();
        idle();
        check("t1_data_a", out_data_a, 32'd5);
        check("t1_data_b", out_data_b, 32'hFFFF_FFFF);
        check("t1_rd",     32'(out_rd), 32'd1);
        check("t1_pend1",  32'(pending[1]), 32'd1);

        // 2: RAW on r2, resolved by bypass in the writeback cycle
        issue(OP_ADD, 2, 0, 0, 16'd8, 1'b1);
        cycle();
        issue(OP_SUB, 4, 2, 0, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t2_stall", 32'(last_ready), 32'd0);
        end
        wb(2, 32'd8);
        cycle();
        check("t2_bypass_ready", 32'(last_ready), 32'd1);
        check("t2_data_a", out_data_a, 32'd8);
        check("t2_data_b", out_data_b, 32'd0);
        wb_en = 1'b0;

        // 3: backpressure holds the SUB result for 5 cycles
        out_ready = 1'b0;
        issue(OP_XOR, 6, 3, 0, 16'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_hold_ready", 32'(last_ready), 32'd0);
            check("t3_hold_a",     out_data_a,      32'd8);
            check("t3_hold_rd",    32'(out_rd),     32'd4);
        end
        out_ready = 1'b1;
        cycle();
        check("t3_release_rd", 32'(out_rd),  32'd6);
        check("t3_release_a",  out_data_a,   32'd5);

        // 4: register 0 ignores writes, never pends, never stalls
        issue(OP_OR, 0, 0, 0, 16'd0, 1'b0);
        wb(0, 32'hDEAD);
        cycle();
        check("t4_ready",  32'(last_ready), 32'd1);
        check("t4_data_a", out_data_a,      32'd0);
        check("t4_data_b", out_data_b,      32'd0);
        wb_en = 1'b0;
        cycle();
        check("t4_no_stall", 32'(last_ready), 32'd1);
        check("t4_pend0",    32'(pending[0]), 32'd0);

        // Retire outstanding destinations
        idle();
        wb(1, 32'd11); cycle();
        wb(2, 32'd22); cycle();
        wb(4, 32'd44); cycle();
        wb(6, 32'd66); cycle();
        idle();

        // 5: eight independent XORs at full rate
        acc_cnt = 0;
        hs_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            issue(OP_XOR, 7 + i, 3, 0, IMM_W'(i), 1'b1);
            cycle();
            acc_cnt += int'(last_ready);
            hs_cnt  += int'(last_hs);
        end
        idle();
        cycle();
        hs_cnt += int'(last_hs);
        check("t5_accepts", 32'(acc_cnt), 32'd8);
        check("t5_outputs", 32'(hs_cnt),  32'd8);

        // 6: same-cycle clear and set of r5; set wins
        issue(OP_ADD, 5, 0, 0, 16'd1, 1'b1);
        cycle();
        check("t6_pend5_set", 32'(pending[5]), 32'd1);
        issue(OP_ADD, 5, 5, 0, 16'd0, 1'b1);
        wb(5, 32'd7);
        cycle();
        check("t6_ready",      32'(last_ready), 32'd1);
        check("t6_data_a",     out_data_a,      32'd7);
        check("t6_pend5_kept", 32'(pending[5]), 32'd1);
        wb_en = 1'b0;

        // Reset mid-stream with a stalled output in flight
        issue(OP_OR, 0, 0, 0, 16'd3, 1'b1);
        out_ready = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",   32'(out_valid), 32'd0);
        check("rst_mid_pending", 32'(pending),   32'd0);
        check("rst_mid_ready",   32'(in_ready),  32'd0);
        check("rst_mid_data_a",  out_data_a,     32'd0);
        model_reset();
        @(negedge clk);
        idle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Randomized traffic over a narrow register range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(3) != 0);
            in_opcode  = OPC_W'($urandom_range(8));
            in_rd      = REG_W'($urandom_range(7));
            in_rs_a    = REG_W'($urandom_range(7));
            in_rs_b    = REG_W'($urandom_range(7));
            in_imm     = IMM_W'($urandom);
            in_use_imm = $urandom_range(1) != 0;
            out_ready  = ($urandom_range(3) != 0);
            wb_en      = ($urandom_range(4) < 2);
            wb_addr    = REG_W'($urandom_range(7));
            wb_data    = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Issue stage directly upstream of the ALU. Accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file. Register-file writes and scoreboard clears come from the writeback port. Stalls on read-after-write and write-after-write hazards. Presents a registered opcode and operand pair (data_a, data_b) to the ALU, plus the destination tag carried alongside for writeback.

Parameters:
DATA_W, 32, operand/result width; matches the ALU data width.
OPC_W, 5, opcode width; opcodes are the `ADD/`SUB/`MPY/`AND/`OR/`XOR/`SHL/`SRL/`SRA macros from defines.vh.
NUM_REGS, 16, register count; register 0 reads as zero.
REG_W, 4, register index width (log2 NUM_REGS).
IMM_W, 16, immediate width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction present
in_ready  out  1  instruction accepted when in_valid && in_ready
in_opcode  in  OPC_W  ALU opcode, passed through unchanged
in_rd  in  REG_W  destination register
in_rs_a  in  REG_W  source register for data_a
in_rs_b  in  REG_W  source register for data_b; ignored when in_use_imm=1
in_imm  in  IMM_W  immediate
in_use_imm  in  1  1: data_b = sign-extended in_imm
out_valid  out  1  operands valid toward ALU
out_ready  in  1  downstream accepts when out_valid && out_ready
out_opcode  out  OPC_W  to ALU opcode
out_data_a  out  DATA_W  to ALU data_a
out_data_b  out  DATA_W  to ALU data_b
out_rd  out  REG_W  destination tag
wb_en  in  1  writeback strobe
wb_addr  in  REG_W  writeback register
wb_data  in  DATA_W  writeback value (ALU data_out after downstream stage)
pending  out  NUM_REGS  scoreboard bit vector, for debug/verification

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all registers = 0, pending = 0, out_valid = 0.
  - out_opcode, out_data_a, out_data_b, out_rd = 0.
  - in_ready is forced low while in reset.
- Register file: NUM_REGS x DATA_W.
  - Write on clk when wb_en && wb_addr != 0.
  - Writes to register 0 are ignored; register 0 always reads 0.
- Operand select:
  - a = reg[in_rs_a].
  - b = in_use_imm ? sign-extended in_imm : reg[in_rs_b].
- Bypass: if wb_en && wb_addr == source && wb_addr != 0 in the same cycle, use wb_data instead of the stored value.
- Hazard: stall when any of the following is pending and not being cleared by a same-cycle wb_en to that address:
  - in_rs_a;
  - in_rs_b (only when !in_use_imm);
  - in_rd.
  Register 0 is never pending.
- in_ready = rst_n && (!out_valid || out_ready) && !hazard. Purely combinational; in_ready must not depend on in_valid.
- Accept edge:
  - out_* <= selected operands, opcode, rd; out_valid <= 1.
  - pending[in_rd] <= 1 when in_rd != 0.
- Latency: accept at edge N gives out_valid=1 from N+1. Back-to-back independent instructions sustain one per cycle while out_ready=1.
- out_valid && out_ready && no new accept: out_valid <= 0 and out_* hold their values.
- Output stability: while out_valid && !out_ready, all out_* hold stable.
- Scoreboard clear: wb_en clears pending[wb_addr].
  - Same-cycle clear and set of the same bit: set wins.
  - wb_en to a non-pending register still writes the register and leaves pending at 0.
- Simultaneous accept and writeback to the same register: the writeback value is both stored and forwarded; there is no stale read.
- Reset mid-operation: the in-flight output is dropped and the scoreboard is cleared. Downstream must discard any in-flight writeback.

Test Plan:
1. Reset, then wb r3=5, issue `ADD rd=1 rs_a=3 use_imm imm=0xFFFF -> next cycle out_data_a=5, out_data_b=0xFFFFFFFF, out_rd=1, pending[1]=1.
2. RAW: issue `ADD rd=2 rs_a=0 imm=8 (wb withheld), then `SUB rd=4 rs_a=2 rs_b=0:
   - in_ready=0 until wb_en r2=8;
   - in that cycle in_ready=1 via bypass, out_data_a=8, out_data_b=0.
3. Backpressure: out_ready=0 with out_valid=1 for 5 cycles -> out_* unchanged, in_ready=0; release -> the queued instruction issues the next cycle.
4. r0: wb r0=0xDEAD, issue `OR rs_a=0 rs_b=0 rd=0 -> data_a=data_b=0, pending stays 0, no stall.
5. Throughput: 8 independent `XOR instructions with out_ready=1 -> 8 outputs in 8 consecutive cycles.
6. Same-cycle set/clear: pending[5]=1, wb_en r5=7 while accepting rd=5 -> r5=7, pending[5] remains 1. Then assert rst_n=0 mid-stream -> out_valid=0 and pending=0 immediately.
